// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared constants, state encoding and func decode for the multiply/divide unit
// Purpose: WIDTH, EX_func codes for MULT/MULTU/DIV/DIVU, MDU state encoding.
// Ports: none (package).
`timescale 1ns/1ps
package mult_div_unit_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    function automatic logic func_is_signed(input logic [5:0] f);
        return (f == FUNC_MULT) || (f == FUNC_DIV);
    endfunction

    function automatic logic func_is_div(input logic [5:0] f);
        return (f == FUNC_DIV) || (f == FUNC_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - EX-stage request/result bundle between pipeline and multiply/divide unit
// Purpose: groups the request (start/func/operands/flush) and response (stall/done/result).
// Ports (signals): start, func[5:0], busA/busB[WIDTH-1:0], flush -> unit;
//                  stall, done, EX_MULT_result[2*WIDTH-1:0] <- unit.
`timescale 1ns/1ps
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic                 start;
    logic [5:0]           func;
    logic [WIDTH-1:0]     busA;
    logic [WIDTH-1:0]     busB;
    logic                 flush;
    logic                 stall;
    logic                 done;
    logic [2*WIDTH-1:0]   EX_MULT_result;

    modport master (
        output start, func, busA, busB, flush,
        input  stall, done, EX_MULT_result
    );

    modport slave (
        input  start, func, busA, busB, flush,
        output stall, done, EX_MULT_result
    );

endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 MULT/MULTU/DIV/DIVU unit for the EX stage
// Purpose: 34-cycle shift-add multiply / restoring divide on operand magnitudes,
//          sign fix-up at the end, stalls the front of the pipeline while busy.
// Ports: clk   - pipeline clock, state updates on the falling edge
//        rst_n - asynchronous active-low reset
//        mdu   - slave side of mult_div_unit_if (start/func/busA/busB/flush in,
//                stall/done/EX_MULT_result out)
`timescale 1ns/1ps
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave mdu
);

    mdu_state_t          r_state;
    mdu_state_t          w_next_state;

    logic [WIDTH-1:0]    r_a;           // dividend / multiplicand magnitude
    logic [WIDTH-1:0]    r_b;           // divisor / multiplier magnitude
    logic [2*WIDTH-1:0]  r_acc;         // product, or {partial remainder, quotient}
    logic [CNT_W-1:0]    r_count;
    logic                r_is_div;
    logic                r_neg_res;     // product / quotient must be negated
    logic                r_neg_a;       // remainder takes the dividend sign
    logic                r_div0;
    logic [2*WIDTH-1:0]  r_result;

    logic                w_signed;
    logic                w_is_div;
    logic                w_div0;
    logic                w_accept;
    logic [WIDTH-1:0]    w_abs_a;
    logic [WIDTH-1:0]    w_abs_b;
    logic [WIDTH:0]      w_rem_sh;
    logic [WIDTH:0]      w_rem_sub;
    logic [2*WIDTH-1:0]  w_acc_step;
    logic [WIDTH-1:0]    w_quo;
    logic [WIDTH-1:0]    w_rem;
    logic [2*WIDTH-1:0]  w_fixed;

    assign w_signed = func_is_signed(mdu.func);
    assign w_is_div = func_is_div(mdu.func);
    assign w_div0   = w_is_div && (mdu.busB == '0);
    assign w_accept = (r_state == IDLE) && mdu.start && !mdu.flush;

    // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
    assign w_abs_a = (w_signed && mdu.busA[WIDTH-1]) ? -mdu.busA : mdu.busA;
    assign w_abs_b = (w_signed && mdu.busB[WIDTH-1]) ? -mdu.busB : mdu.busB;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (mdu.flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (mdu.start) w_next_state = w_div0 ? FIX : CALC;
                CALC:    if (r_count == '0) w_next_state = FIX;
                FIX:     w_next_state = DONE;
                // The stalled instruction still presents start here; never retrigger.
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // One radix-2 step, MSB first, indexed by the down-counter.
    always_comb begin
        w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_a[r_count]};
        w_rem_sub  = w_rem_sh - {1'b0, r_b};
        w_acc_step = r_acc;
        if (r_is_div) begin
            // Borrow bit clear means the shifted remainder covered the divisor.
            if (!w_rem_sub[WIDTH]) begin
                w_acc_step = {w_rem_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0}
                       + (r_b[r_count] ? {{WIDTH{1'b0}}, r_a} : {2*WIDTH{1'b0}});
        end
    end

    always_comb begin
        w_quo   = r_acc[WIDTH-1:0];
        w_rem   = r_acc[2*WIDTH-1:WIDTH];
        w_fixed = r_acc;
        if (r_div0) begin
            // Restoring the dividend sign on |busA| gives back busA unchanged.
            w_fixed = {(r_neg_a ? -r_a : r_a), {WIDTH{1'b1}}};
        end else if (r_is_div) begin
            w_fixed = {(r_neg_a ? -w_rem : w_rem), (r_neg_res ? -w_quo : w_quo)};
        end else begin
            w_fixed = r_neg_res ? -r_acc : r_acc;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_a   <= 1'b0;
            r_div0    <= 1'b0;
            r_result  <= '0;
        end else if (!mdu.flush) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a       <= w_abs_a;
                        r_b       <= w_abs_b;
                        r_acc     <= '0;
                        r_count   <= CNT_W'(WIDTH - 1);
                        r_is_div  <= w_is_div;
                        r_neg_res <= w_signed && (mdu.busA[WIDTH-1] ^ mdu.busB[WIDTH-1]);
                        r_neg_a   <= w_signed && mdu.busA[WIDTH-1];
                        r_div0    <= w_div0;
                    end
                end
                CALC: begin
                    r_acc   <= w_acc_step;
                    r_count <= r_count - 1'b1;
                end
                FIX: begin
                    r_result <= w_fixed;
                end
                default: ;
            endcase
        end
    end

    // Stall is held low during reset and in the cycle a flush is seen.
    assign mdu.stall = rst_n && !mdu.flush &&
                       (((r_state == IDLE) && mdu.start) || (r_state == CALC) || (r_state == FIX));
    assign mdu.done           = (r_state == DONE) && !mdu.flush;
    assign mdu.EX_MULT_result = r_result;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
`timescale 1ns/1ps
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [63:0] last_res;

    mult_div_unit_if mif ();

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, p, q, r;
        logic [63:0] pv, qv, rv;
        if (f == FUNC_MULT || f == FUNC_DIV) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'h0, a});
            lb = longint'({32'h0, b});
        end
        if (f == FUNC_MULT || f == FUNC_MULTU) begin
            p  = la * lb;
            pv = p;
            return pv;
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q  = la / lb;
        r  = la % lb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    function automatic int model_stalls(input logic [5:0] f, input logic [31:0] b);
        if ((f == FUNC_DIV || f == FUNC_DIVU) && b == 32'h0) return 2;
        return 34;
    endfunction

    // Presents one request and runs until done (bounded). Stall is counted in every
    // cycle including the done cycle; start is left high for the caller to release.
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int n_stall, output logic [63:0] res, output bit got_done);
        @(posedge clk);
        mif.flush = 1'b0;
        mif.start = 1'b1;
        mif.func  = f;
        mif.busA  = a;
        mif.busB  = b;
        #1;
        n_stall  = 0;
        got_done = 1'b0;
        res      = '0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (mif.stall) n_stall++;
            if (mif.done) begin
                got_done = 1'b1;
                res      = mif.EX_MULT_result;
                break;
            end
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        mif.start = 1'b0;
        mif.flush = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mif.start = 1'b0;
        mif.flush = 1'b0;
        mif.func  = FUNC_MULT;
        mif.busA  = '0;
        mif.busB  = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (mif.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", mif.stall); end
        total++; if (mif.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", mif.done); end
        total++; if (mif.EX_MULT_result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h want=0", mif.EX_MULT_result); end
        rst_n    = 1'b1;
        last_res = 64'h0;
    endtask

    task automatic test_directed();
        logic [5:0]  tf [9] = '{FUNC_MULTU, FUNC_MULT, FUNC_DIV, FUNC_DIVU, FUNC_DIV,
                                FUNC_MULT, FUNC_DIVU, FUNC_DIV, FUNC_DIV};
        logic [31:0] ta [9] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd100, 32'h80000000,
                                32'h80000000, 32'hFFFFFFFF, 32'd7, 32'h80000000};
        logic [31:0] tb [9] = '{32'hFFFFFFFF, 32'd3, 32'd2, 32'd0, 32'hFFFFFFFF,
                                32'h80000000, 32'd7, 32'hFFFFFFFE, 32'd0};
        logic [63:0] te [9] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFFA, 64'hFFFFFFFF_FFFFFFFD,
                                64'h00000064_FFFFFFFF, 64'h00000000_80000000, 64'h40000000_00000000,
                                64'h00000003_24924924, 64'h00000001_FFFFFFFD, 64'h80000000_FFFFFFFF};
        int          ts [9] = '{34, 34, 34, 2, 34, 34, 34, 34, 2};
        int          n_stall;
        logic [63:0] res;
        bit          got;
        for (int i = 0; i < 9; i++) begin
            do_op(tf[i], ta[i], tb[i], n_stall, res, got);
            total++; if (!got) begin bad++; $display("FAIL dir%0d_done got=timeout want=done", i); end
            total++; if (res !== te[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, te[i]); end
            total++; if (n_stall != ts[i]) begin bad++; $display("FAIL dir%0d_stalls got=%0d want=%0d", i, n_stall, ts[i]); end
            go_idle();
            total++; if (mif.done !== 1'b0) begin bad++; $display("FAIL dir%0d_done_pulse got=%b want=0", i, mif.done); end
            total++; if (mif.EX_MULT_result !== te[i]) begin bad++; $display("FAIL dir%0d_hold got=%h want=%h", i, mif.EX_MULT_result, te[i]); end
            last_res = te[i];
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [4] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [63:0] exp_res, res;
        int          n_stall, exp_st;
        bit          got;
        for (int i = 0; i < 24; i++) begin
            f = FUNC_MULT + 6'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            exp_res = model(f, a, b);
            exp_st  = model_stalls(f, b);
            do_op(f, a, b, n_stall, res, got);
            total++; if (!got || res !== exp_res) begin bad++; $display("FAIL rnd%0d_result f=%h a=%h b=%h got=%h want=%h done=%0d", i, f, a, b, res, exp_res, got); end
            total++; if (n_stall != exp_st) begin bad++; $display("FAIL rnd%0d_stalls got=%0d want=%0d", i, n_stall, exp_st); end
            last_res = exp_res;
            if ($urandom_range(0, 1) == 0) go_idle();
        end
        go_idle();
    endtask

    task automatic test_flush();
        int          n_stall;
        logic [63:0] res;
        bit          got;
        @(posedge clk);
        mif.start = 1'b1;
        mif.func  = FUNC_MULTU;
        mif.busA  = 32'h12345678;
        mif.busB  = 32'h9ABCDEF0;
        repeat (10) @(posedge clk);
        mif.flush = 1'b1;
        #1;
        total++; if (mif.stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", mif.stall); end
        total++; if (mif.done !== 1'b0) begin bad++; $display("FAIL flush_done got=%b want=0", mif.done); end
        @(negedge clk);
        #2;
        total++; if (mif.EX_MULT_result !== last_res) begin bad++; $display("FAIL flush_result got=%h want=%h", mif.EX_MULT_result, last_res); end
        total++; if (mif.done !== 1'b0) begin bad++; $display("FAIL flush_no_done got=%b want=0", mif.done); end
        do_op(FUNC_MULT, 32'hFFFFFFF9, 32'd6, n_stall, res, got);
        total++; if (!got || res !== 64'hFFFFFFFF_FFFFFFD6) begin bad++; $display("FAIL flush_restart_result got=%h want=ffffffffffffffd6 done=%0d", res, got); end
        total++; if (n_stall != 34) begin bad++; $display("FAIL flush_restart_stalls got=%0d want=34", n_stall); end
        last_res = 64'hFFFFFFFF_FFFFFFD6;
        go_idle();
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        mif.start = 1'b1;
        mif.func  = FUNC_DIVU;
        mif.busA  = 32'hDEADBEEF;
        mif.busB  = 32'd13;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (mif.stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b want=0", mif.stall); end
        total++; if (mif.done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", mif.done); end
        total++; if (mif.EX_MULT_result !== 64'h0) begin bad++; $display("FAIL rstmid_result got=%h want=0", mif.EX_MULT_result); end
        @(posedge clk);
        mif.start = 1'b0;
        rst_n     = 1'b1;
        last_res  = 64'h0;
    endtask

    task automatic test_back_to_back();
        int          n_stall;
        logic [63:0] res;
        bit          got;
        do_op(FUNC_MULT, 32'd1000, 32'hFFFFFFFF, n_stall, res, got);
        total++; if (!got || res !== 64'hFFFFFFFF_FFFFFC18) begin bad++; $display("FAIL b2b_first got=%h want=fffffffffffffc18 done=%0d", res, got); end
        total++; if (n_stall != 34) begin bad++; $display("FAIL b2b_first_stalls got=%0d want=34", n_stall); end
        // start stays high through DONE; the next instruction follows immediately.
        do_op(FUNC_MULTU, 32'h0001_0000, 32'h0003_0000, n_stall, res, got);
        total++; if (!got || res !== 64'h00000003_00000000) begin bad++; $display("FAIL b2b_second got=%h want=0000000300000000 done=%0d", res, got); end
        total++; if (n_stall != 34) begin bad++; $display("FAIL b2b_second_stalls got=%0d want=34", n_stall); end
        go_idle();
        total++; if (mif.stall !== 1'b0 || mif.done !== 1'b0) begin bad++; $display("FAIL b2b_idle got=stall%b/done%b want=0/0", mif.stall, mif.done); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
